// File: rtl/demo_cmd_parser.sv
// demo_cmd_parser: splits the USB CDC bulk OUT byte stream into plain data
// bytes (towards the loopback RAM) and escape-prefixed command frames
// {opcode, 24-bit little-endian argument} for the demo app sequencer.
// Build macro ARG_TIMEOUT_EN: abort an incomplete frame after TIMEOUT_CYCLES
// consecutive cycles without an accepted byte while inside ESC/ARG.
module demo_cmd_parser #(
  parameter logic [7:0] PREFIX         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic [2:0]  cmd_o,
  output logic [23:0] arg_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    ESC,
    ARG,
    CMD
  } state_t;

  localparam logic [2:0] OP_WAIT = 3'd1;

  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [23:0] arg_q, arg_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        err_q, err_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  last_q, last_d;
  logic        in_ready;
  logic        accept;
  logic        opcode_ok;

`ifdef ARG_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Input backpressure: header bytes need room in the data register, argument
  // bytes are always taken, and nothing is taken while a command is pending.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE, ESC: in_ready = ~data_valid_q | data_ready_i;
      ARG:       in_ready = 1'b1;
      default:   in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid_i & in_ready;
  assign opcode_ok = (in_data_i[7:3] == 5'd0) && (in_data_i[2:0] != 3'd0);

  // Next-state and output-register logic for the frame parser.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    cmd_valid_d  = cmd_valid_q;
    err_d        = 1'b0;
    idx_d        = idx_q;
    last_d       = last_q;
`ifdef ARG_TIMEOUT_EN
    tmo_d        = '0;
`endif

    if (data_valid_q && data_ready_i) begin
      data_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_data_i == PREFIX) begin
            state_d = ESC;
          end else begin
            data_d       = in_data_i;
            data_valid_d = 1'b1;
          end
        end
      end
      ESC: begin
        if (accept) begin
          if (in_data_i == PREFIX) begin
            data_d       = PREFIX;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else if (opcode_ok) begin
            cmd_d   = in_data_i[2:0];
            arg_d   = '0;
            idx_d   = 2'd0;
            last_d  = (in_data_i[2:0] == OP_WAIT) ? 2'd0 : 2'd2;
            state_d = ARG;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ARG: begin
        if (accept) begin
          case (idx_q)
            2'd0:    arg_d[7:0]   = in_data_i;
            2'd1:    arg_d[15:8]  = in_data_i;
            default: arg_d[23:16] = in_data_i;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == last_q) begin
            state_d = CMD;
            if (!data_valid_d) begin
              cmd_valid_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (cmd_valid_q && cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (!cmd_valid_q && !data_valid_d) begin
          cmd_valid_d = 1'b1;
        end
      end
    endcase

`ifdef ARG_TIMEOUT_EN
    if ((state_q == ESC || state_q == ARG) && !accept) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      cmd_q        <= '0;
      arg_q        <= '0;
      cmd_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      last_q       <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      cmd_valid_q  <= cmd_valid_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
    end
  end

`ifdef ARG_TIMEOUT_EN
  // Idle-cycle counter for the frame timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign in_ready_o   = in_ready;
  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign cmd_o        = cmd_q;
  assign arg_o        = arg_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != IDLE);

endmodule
